// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART receiver front end.
// The optional rx synchronizer is selected with the UART_RX_SYNC_EN macro.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int CLKS_PER_BIT_DEF = 20;
    localparam int DATA_BITS_DEF    = 8;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; both stages reset to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart.sv
// Oversampling UART receiver front end: mid-bit / bit-end strobes and a frame-valid strobe.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx (adds 2 cycles of latency).
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic out10,
    output logic out20,
    output logic outf
);

    localparam int CW   = cnt_width(CLKS_PER_BIT);
    localparam int IW   = cnt_width(DATA_BITS);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    uart_state_e           state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q,   shift_d;
    logic                  out10_q,   out10_d;
    logic                  out20_q,   out20_d;
    logic                  outf_q,    outf_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        out10_d   = 1'b0;
        out20_d   = 1'b0;
        outf_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                // A start bit that is high again at its midpoint is a glitch: drop it silently.
                if (cnt_q == CNT_MID) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        out10_d = 1'b1;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    out20_d   = 1'b1;
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end

            DATA: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_MID) begin
                    out10_d = 1'b1;
                    shift_d = DATA_BITS'({rx_s, shift_q} >> 1);
                end
                if (cnt_q == CNT_LAST) begin
                    out20_d = 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + 1'b1;
                // Leave at the stop-bit midpoint so a start edge half a bit later is caught.
                if (cnt_q == CNT_MID) begin
                    out10_d = 1'b1;
                    outf_d  = rx_s;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            out10_q   <= 1'b0;
            out20_q   <= 1'b0;
            outf_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            out10_q   <= out10_d;
            out20_q   <= out20_d;
            outf_q    <= outf_d;
        end
    end

    assign out10 = out10_q;
    assign out20 = out20_q;
    assign outf  = outf_q;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: random frames against an event-time reference model.
module tb_uart;

    localparam int CPB  = 20;
    localparam int HALF = CPB / 2;
    localparam int DB   = 8;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int NO_CUT = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic out10, out20, outf;

    uart #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .out10 (out10),
        .out20 (out20),
        .outf  (outf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobe times (edge numbers) and the byte seen at each outf.
    int q10[$];
    int q20[$];
    int qf[$];
    int qb[$];
    always @(negedge clk) begin
        if (out10) q10.push_back(cyc);
        if (out20) q20.push_back(cyc);
        if (outf) begin
            qf.push_back(cyc);
            qb.push_back(int'(dut.shift_q));
        end
    end

    // Expected strobe times from the reference model.
    int e10[$];
    int e20[$];
    int ef[$];
    int eb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a frame whose start edge is first seen at edge e0 produces strobes at
    // fixed offsets; anything at or after a reset edge (cut) never appears.
    function automatic void model_frame(input int e0, input logic [7:0] data, input bit stop,
                                        input int cut);
        int e = e0 + SYNC;
        for (int k = 0; k <= DB; k++) begin
            if (e + HALF + k * CPB < cut) e10.push_back(e + HALF + k * CPB);
            if (e + (k + 1) * CPB < cut) e20.push_back(e + (k + 1) * CPB);
        end
        if (e + HALF + (DB + 1) * CPB < cut) begin
            e10.push_back(e + HALF + (DB + 1) * CPB);
            if (stop) begin
                ef.push_back(e + HALF + (DB + 1) * CPB);
                eb.push_back(int'(data));
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx = 1'b1;
        end
    endtask

    // Drive one frame; rst_at >= 0 pulses reset at that cycle offset and aborts the frame.
    task automatic send_frame(input logic [7:0] data, input bit stop, input int rst_at);
        bit b[10];
        int e0 = 0;
        int cut = NO_CUT;
        b[0] = 1'b0;
        for (int k = 0; k < DB; k++) b[k + 1] = data[k];
        b[9] = stop;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) e0 = cyc + 1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("rst_out10", {31'd0, out10}, 0);
                check("rst_out20", {31'd0, out20}, 0);
                check("rst_outf",  {31'd0, outf},  0);
                rst = 1'b0;
                rx  = 1'b1;
                break;
            end
            rx = b[i / CPB];
            if (i == rst_at) begin
                rst = 1'b1;
                cut = cyc + 1;
            end
        end
        model_frame(e0, data, stop, cut);
    endtask

    initial begin
        logic [7:0] d;
        bit         s;

        // Reset with rx idle.
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out10", {31'd0, out10}, 0);
        check("reset_out20", {31'd0, out20}, 0);
        check("reset_outf",  {31'd0, outf},  0);
        check("reset_state", 32'(dut.state_q), 0);
        rst = 1'b0;
        idle(20);
        check("idle_strobes", q10.size() + q20.size() + qf.size(), 0);

        // Fixed 0x55 frame.
        send_frame(8'h55, 1'b1, -1);
        idle(5);
        check("byte_55", 32'(dut.shift_q), 32'h55);

        // Start glitch: 5 low cycles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rx = 1'b0;
        end
        idle(25);
        check("glitch_state", 32'(dut.state_q), 0);

        // Framing error followed by a valid 0x00 frame.
        send_frame(8'hFF, 1'b0, -1);
        idle(15);
        send_frame(8'h00, 1'b1, -1);
        idle(10);

        // Mid-frame reset during data bit 3, then a clean random frame.
        send_frame(8'($urandom_range(0, 255)), 1'b1, CPB * 4 + 5);
        idle(10);
        send_frame(8'($urandom_range(0, 255)), 1'b1, -1);
        idle(10);

        // Back-to-back 0xA3 frames with a single stop bit between them.
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'hA3, 1'b1, -1);
        idle(15);
        check("b2b_outf_count", qf.size(), ef.size());
        if (qf.size() >= 2) check("b2b_gap", qf[$] - qf[$-1], CPB * (DB + 2));

        // Random frames, occasional framing errors, random gaps.
        for (int f = 0; f < 8; f++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, s, -1);
            idle(s ? $urandom_range(0, 30) : 12 + $urandom_range(0, 20));
        end
        idle(CPB * 2);

        // Full event-trace comparison against the model.
        check("n_out10", q10.size(), e10.size());
        check("n_out20", q20.size(), e20.size());
        check("n_outf",  qf.size(),  ef.size());
        for (int i = 0; i < q10.size() && i < e10.size(); i++) check("t_out10", q10[i], e10[i]);
        for (int i = 0; i < q20.size() && i < e20.size(); i++) check("t_out20", q20[i], e20[i]);
        for (int i = 0; i < qf.size() && i < ef.size(); i++) begin
            check("t_outf", qf[i], ef[i]);
            check("byte", qb[i], eb[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
